stream_mux2_rr: RTL
===================

// Module: stream_mux2_rr
// PURPOSE
//  - Merges two valid/ready input streams (ch0, ch1) onto one output stream; inverse of the 1:2 demux path.
//  - Round-robin arbitration, registered output (1 slot), source tag travels with each beat.
//  - Sits at the aggregation point that feeds a shared downstream consumer.
// PARAMETERS
//  - DW  8  data width of each beat
// PORTS
//  - clk        in   1   single clock, all state on rising edge
//  - rst_n      in   1   asynchronous active-low reset
//  - in0_valid  in   1   ch0 beat present
//  - in0_data   in   DW  ch0 payload
//  - in0_ready  out  1   ch0 beat accepted this cycle when in0_valid && in0_ready
//  - in1_valid  in   1   ch1 beat present
//  - in1_data   in   DW  ch1 payload
//  - in1_ready  out  1   ch1 beat accepted this cycle when in1_valid && in1_ready
//  - out_valid  out  1   registered output beat present
//  - out_data   out  DW  registered payload
//  - out_src    out  1   source of current beat: 0 = ch0, 1 = ch1
//  - out_ready  in   1   downstream accepts when out_valid && out_ready
//  - in0_last, in1_last  in  1  only with STREAM_MUX_PKT_LOCK_EN
// BEHAVIOUR
//  - Reset (async on rst_n=0): out_valid=0, out_data=0, out_src=0, prio=0 (ch0 favoured), state=IDLE.
//  - Slot free: load_ok = !out_valid || out_ready; combinational.
//  - Grant: only one requester valid -> grant it. Both valid -> grant ch[prio].
//  - inK_ready = grant[K] && load_ok. Never both high. May depend combinationally on out_ready.
//  - Accept (granted && valid && load_ok):
//    - Next edge: out_valid=1, out_data=inK_data, out_src=K.
//    - prio <= ~K, so the other channel wins the next tie.
//  - Latency: 1 cycle input->output. Throughput: 1 beat/cycle with out_ready held at 1.
//  - Backpressure: out_valid && !out_ready -> both in_ready=0; out_data/out_src held stable.
//  - Drain: out_ready=1 and no input accept -> out_valid <= 0.
//  - Input not valid: the ungranted channel's data is ignored; no beat is dropped or duplicated.
//  - Both idle: prio unchanged.
//  - Reset mid-transfer: the in-flight output beat is discarded.
//  - Input valid rule: a source must hold valid/data until accepted. The block does not check this.
//  - FSM (meaningful only with lock): IDLE -> LOCK0/LOCK1 on accept of a non-last beat from ch0/ch1.
//    LOCKk -> IDLE on accept of a beat from chk with last=1.
// CONFIGURATION
//  - `STREAM_MUX_PKT_LOCK_EN defined:
//    - Adds in0_last/in1_last.
//    - In LOCKk only chk can be granted, even if the other channel is valid and favoured.
//    - prio updates only on the accept of a last beat.
//    - Single-beat packet (last=1 on the first beat) stays in IDLE.
//  - Not defined:
//    - No last ports; FSM stays in IDLE.
//    - Every beat is arbitrated independently.
// STRUCTURE
//  - Package stream_mux_pkg:
//    - typedef logic src_t.
//    - typedef enum {IDLE, LOCK0, LOCK1} mux_state_t.
//    - localparam src_t SRC_CH0 = 1'b0, SRC_CH1 = 1'b1.
//  - Sub-module rr_arb2:
//    - Inputs: req[1:0], load_ok, lock/lock_id.
//    - Output: one-hot grant[1:0].
//    - Owns the prio flop.
//  - Top holds the output register and the lock FSM.
// TESTING
//  1 Reset: rst_n=0 with inputs toggling -> out_valid=0, out_data=0, out_src=0, both in_ready=0 or gated by grant.
//  2 Single source: ch0 sends 0x11,0x22,0x33 back-to-back, out_ready=1.
//    -> out 0x11/0x22/0x33, src=0, one cycle after each accept, no bubbles.
//  3 Contention: ch0=0xA0, ch1=0xB0 held valid, out_ready=1.
//    -> output alternates A0(src0), B0(src1), A0, B0...; first winner is ch0.
//  4 Backpressure: out holds 0x5A, out_ready=0 for 3 cycles with both inputs valid.
//    -> in_ready=0 on both, out stable. Release -> 0x5A leaves, next beat loads same edge.
//  5 Reset mid-stream: rst_n low while out_valid=1.
//    -> out_valid=0 immediately (async); after release ch0 wins the first tie.
//  6 Lock (macro on): ch0 sends 3-beat packet C1,C2,C3(last) while ch1 holds D1 valid.
//    -> C1,C2,C3 then D1; no interleave. Macro off: C1,D1,C2,C3 order.

Source files
------------

// File: rtl/stream_mux2_rr_pkg.sv
// stream_mux_pkg: shared types and source-tag constants for the 2:1 round-robin stream mux.
package stream_mux_pkg;
   typedef logic src_t;
   typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} mux_state_t;
   localparam src_t SRC_CH0 = 1'b0;
   localparam src_t SRC_CH1 = 1'b1;
endpackage

// File: rtl/stream_mux2_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter with packet lock override; owns the priority flop.
module rr_arb2
   import stream_mux_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       load_ok,
   input  logic       lock,
   input  src_t       lock_id,
   input  logic       upd,
   output logic [1:0] grant
);
   src_t prio;
   // A lock pins the grant to its channel even while that channel is momentarily idle.
   always_comb grant = lock ? {lock_id, ~lock_id} : (&req ? {prio, ~prio} : req);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) prio <= SRC_CH0;
      else if (load_ok && |(grant & req) && upd) prio <= ~grant[1];
endmodule

// File: rtl/stream_mux2_rr.sv
// stream_mux2_rr: merges two valid/ready streams into one registered output with round-robin arbitration.
// Optional packet lock (in0_last/in1_last ports) is enabled with STREAM_MUX_PKT_LOCK_EN.
module stream_mux2_rr
   import stream_mux_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in0_valid,
   input  logic [DW-1:0] in0_data,
   output logic          in0_ready,
   input  logic          in1_valid,
   input  logic [DW-1:0] in1_data,
   output logic          in1_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
   input  logic          in0_last,
   input  logic          in1_last,
`endif
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output src_t          out_src,
   input  logic          out_ready
);
   logic [1:0] grant;
   logic       load_ok, acc, last;
   src_t       src;
   mux_state_t state;
   always_comb begin
      load_ok   = !out_valid || out_ready;
      src       = grant[1] ? SRC_CH1 : SRC_CH0;
      acc       = load_ok && |(grant & {in1_valid, in0_valid});
      in0_ready = grant[0] && load_ok;
      in1_ready = grant[1] && load_ok;
`ifdef STREAM_MUX_PKT_LOCK_EN
      last      = src ? in1_last : in0_last;
`else
      last      = 1'b1;
`endif
   end
   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     ({in1_valid, in0_valid}),
      .load_ok (load_ok),
      .lock    (state != IDLE),
      .lock_id (state == LOCK1),
      .upd     (last),
      .grant   (grant)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= SRC_CH0;
      end else if (acc) begin
         out_valid <= 1'b1;
         out_data  <= src ? in1_data : in0_data;
         out_src   <= src;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   // Without packet lock, last is tied high so the FSM never leaves IDLE.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else if (acc) state <= last ? IDLE : (src ? LOCK1 : LOCK0);
endmodule
